// File: rtl/issue_unit_arbiter_if.sv
// rtl/issue_unit_arbiter_if.sv - issue arbiter handshake bundle (IBuffer/OC/RAU side)
interface issue_unit_arbiter_if #(
   parameter int NUM_WARPS = 8,
   parameter int WID_W     = $clog2(NUM_WARPS)
);
   logic                 Start_IU;
   logic [NUM_WARPS-1:0] WarpMask_IU;
   logic [NUM_WARPS-1:0] Req_IB_IU;
   logic [NUM_WARPS-1:0] Grt_IU_IB;
   logic [NUM_WARPS-1:0] Exit_Req_IB_IU;
   logic [NUM_WARPS-1:0] Exit_Grt_IU_IB;
   logic                 Stall_OC_IU;
   logic                 Valid_IU_OC;
   logic [WID_W-1:0]     WarpID_IU_OC;
   logic                 Exit_Valid_IU_RAU;
   logic [WID_W-1:0]     Exit_WarpID_IU_RAU;
   logic                 Busy_IU;
   logic                 Done_IU;
   logic [15:0]          IssueCnt_IU;

   // arbiter side
   modport slave (
      input  Start_IU, WarpMask_IU, Req_IB_IU, Exit_Req_IB_IU, Stall_OC_IU,
      output Grt_IU_IB, Exit_Grt_IU_IB, Valid_IU_OC, WarpID_IU_OC,
             Exit_Valid_IU_RAU, Exit_WarpID_IU_RAU, Busy_IU, Done_IU, IssueCnt_IU
   );

   // requester / launcher side
   modport master (
      output Start_IU, WarpMask_IU, Req_IB_IU, Exit_Req_IB_IU, Stall_OC_IU,
      input  Grt_IU_IB, Exit_Grt_IU_IB, Valid_IU_OC, WarpID_IU_OC,
             Exit_Valid_IU_RAU, Exit_WarpID_IU_RAU, Busy_IU, Done_IU, IssueCnt_IU
   );
endinterface

// File: rtl/issue_unit_arbiter.sv
// rtl/issue_unit_arbiter.sv - round-robin issue / fixed-priority exit arbiter with warp residency
module issue_unit_arbiter #(
   parameter int NUM_WARPS = 8,
   parameter int WID_W     = $clog2(NUM_WARPS)
) (
   input  logic                   clk,
   input  logic                   rst,
   issue_unit_arbiter_if.slave    bus
);

   logic [NUM_WARPS-1:0] active;
   logic [WID_W-1:0]     ptr;
   logic [15:0]          issue_cnt;
   logic                 valid_q;
   logic [WID_W-1:0]     wid_q;
   logic                 exit_valid_q;
   logic [WID_W-1:0]     exit_wid_q;
   logic                 done_q;

   logic [NUM_WARPS-1:0] exit_elig;
   logic [NUM_WARPS-1:0] exit_grt;
   logic                 exit_hit;
   logic [WID_W-1:0]     exit_id;

   logic [NUM_WARPS-1:0] iss_elig;
   logic [NUM_WARPS-1:0] iss_grt;
   logic                 iss_hit;
   logic [WID_W-1:0]     iss_id;
   logic [WID_W-1:0]     scan_idx;

   logic                 busy;

   assign busy = |active;

   // Exit arbitration: lowest-index resident warp wins, unaffected by OC stall
   always_comb begin
      exit_elig = bus.Exit_Req_IB_IU & active;
      exit_grt  = '0;
      exit_hit  = 1'b0;
      exit_id   = '0;
      for (int i = 0; i < NUM_WARPS; i++) begin
         if (!exit_hit && exit_elig[i]) begin
            exit_hit    = 1'b1;
            exit_grt[i] = 1'b1;
            exit_id     = WID_W'(i);
         end
      end
   end

   // Issue arbitration: scan from ptr with wrap; an exiting warp cannot also issue
   always_comb begin
      iss_elig = bus.Req_IB_IU & active & ~exit_grt;
      if (bus.Stall_OC_IU) begin
         iss_elig = '0;
      end
      iss_grt  = '0;
      iss_hit  = 1'b0;
      iss_id   = '0;
      scan_idx = '0;
      for (int k = 0; k < NUM_WARPS; k++) begin
         scan_idx = ptr + WID_W'(k);
         if (!iss_hit && iss_elig[scan_idx]) begin
            iss_hit           = 1'b1;
            iss_grt[scan_idx] = 1'b1;
            iss_id            = scan_idx;
         end
      end
   end

   // Residency, pointer, counter and registered downstream reports
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         active       <= '0;
         ptr          <= '0;
         issue_cnt    <= '0;
         valid_q      <= 1'b0;
         wid_q        <= '0;
         exit_valid_q <= 1'b0;
         exit_wid_q   <= '0;
         done_q       <= 1'b0;
      end else begin
         valid_q      <= iss_hit;
         exit_valid_q <= exit_hit;
         if (iss_hit) begin
            wid_q <= iss_id;
         end
         if (exit_hit) begin
            exit_wid_q <= exit_id;
         end
         // last resident warp leaving: the only set bit is the one granted
         done_q <= exit_hit && (active == exit_grt);

         if (bus.Start_IU && !busy) begin
            active    <= bus.WarpMask_IU;
            ptr       <= '0;
            issue_cnt <= '0;
         end else begin
            active <= active & ~exit_grt;
            if (iss_hit) begin
               ptr <= iss_id + WID_W'(1);
               if (issue_cnt != 16'hFFFF) begin
                  issue_cnt <= issue_cnt + 16'd1;
               end
            end
         end
      end
   end

   assign bus.Grt_IU_IB          = iss_grt;
   assign bus.Exit_Grt_IU_IB     = exit_grt;
   assign bus.Valid_IU_OC        = valid_q;
   assign bus.WarpID_IU_OC       = wid_q;
   assign bus.Exit_Valid_IU_RAU  = exit_valid_q;
   assign bus.Exit_WarpID_IU_RAU = exit_wid_q;
   assign bus.Busy_IU            = busy;
   assign bus.Done_IU            = done_q;
   assign bus.IssueCnt_IU        = issue_cnt;

endmodule

// File: tb/tb_issue_unit_arbiter.sv
// tb/tb_issue_unit_arbiter.sv - scoreboard bench for issue_unit_arbiter
module tb_issue_unit_arbiter;
   localparam int N = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   issue_unit_arbiter_if #(.NUM_WARPS(N)) bus();
   issue_unit_arbiter #(.NUM_WARPS(N)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic       v;
      logic [2:0] id;
      logic       ev;
      logic [2:0] eid;
      logic       done;
      logic       busy;
      logic [15:0] cnt;
   } exp_t;

   exp_t q[$];

   // reference model state
   logic [7:0] m_act;
   int         m_ptr;
   int         m_cnt;
   logic [2:0] m_id;
   logic [2:0] m_eid;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   task automatic model_clear();
      m_act = '0; m_ptr = 0; m_cnt = 0; m_id = '0; m_eid = '0;
   endtask

   // Entered at posedge+1; drives one cycle, checks grants, pushes expected registered outputs
   task automatic step(input logic st, input logic [7:0] mask, input logic [7:0] req,
                       input logic [7:0] ereq, input logic stall, output logic [7:0] g);
      exp_t e;
      int eg, ig, w;
      logic [7:0] eg_v, ig_v;
      bus.Start_IU       = st;
      bus.WarpMask_IU    = mask;
      bus.Req_IB_IU      = req;
      bus.Exit_Req_IB_IU = ereq;
      bus.Stall_OC_IU    = stall;
      #3;
      eg = -1;
      for (int i = 0; i < N; i++) if (eg < 0 && ereq[i] && m_act[i]) eg = i;
      ig = -1;
      if (!stall) begin
         for (int k = 0; k < N; k++) begin
            w = (m_ptr + k) % N;
            if (ig < 0 && req[w] && m_act[w] && w != eg) ig = w;
         end
      end
      eg_v = (eg < 0) ? 8'h00 : (8'd1 << eg);
      ig_v = (ig < 0) ? 8'h00 : (8'd1 << ig);
      chk("issue_grant", 32'(bus.Grt_IU_IB), 32'(ig_v));
      chk("exit_grant", 32'(bus.Exit_Grt_IU_IB), 32'(eg_v));
      g = bus.Grt_IU_IB;

      e.done = (eg >= 0) && ($countones(m_act) == 1);
      if (st && m_act == 8'h00) begin
         m_act = mask; m_ptr = 0; m_cnt = 0;
      end else begin
         if (eg >= 0) m_act[eg] = 1'b0;
         if (ig >= 0) begin
            m_ptr = (ig + 1) % N;
            if (m_cnt < 65535) m_cnt++;
         end
      end
      if (ig >= 0) m_id = ig[2:0];
      if (eg >= 0) m_eid = eg[2:0];
      e.v = (ig >= 0); e.id = m_id;
      e.ev = (eg >= 0); e.eid = m_eid;
      e.busy = (m_act != 8'h00);
      e.cnt = m_cnt[15:0];
      q.push_back(e);
      @(posedge clk);
      #1;
      bus.Start_IU = 1'b0;
   endtask

   task automatic idle(input int n);
      logic [7:0] g;
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, g);
   endtask

   // Entered at posedge+1; asserts reset mid-cycle, leaves inputs as they were
   task automatic mid_reset();
      #2;
      rst = 1'b0;
      #1;
      chk("rst_grt", 32'(bus.Grt_IU_IB), 0);
      chk("rst_exit_grt", 32'(bus.Exit_Grt_IU_IB), 0);
      chk("rst_valid", 32'(bus.Valid_IU_OC), 0);
      chk("rst_exit_valid", 32'(bus.Exit_Valid_IU_RAU), 0);
      chk("rst_busy", 32'(bus.Busy_IU), 0);
      chk("rst_done", 32'(bus.Done_IU), 0);
      chk("rst_cnt", 32'(bus.IssueCnt_IU), 0);
      chk("rst_wid", 32'(bus.WarpID_IU_OC), 0);
      q.delete();
      model_clear();
      #1;
      rst = 1'b1;
      bus.Req_IB_IU = '0;
      bus.Exit_Req_IB_IU = '0;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      logic [7:0] g;
      int guard;
      guard = 0;
      while (m_act != 8'h00 && guard < 20) begin
         step(1'b0, 8'h00, 8'h00, 8'hFF, 1'b0, g);
         guard++;
      end
      chk("drain_bound", 32'(m_act), 0);
      idle(1);
   endtask

   // Monitor: compares registered outputs against the scoreboard after every edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("valid_oc", 32'(bus.Valid_IU_OC), 32'(e.v));
            chk("warpid_oc", 32'(bus.WarpID_IU_OC), 32'(e.id));
            chk("exit_valid", 32'(bus.Exit_Valid_IU_RAU), 32'(e.ev));
            chk("exit_warpid", 32'(bus.Exit_WarpID_IU_RAU), 32'(e.eid));
            chk("done", 32'(bus.Done_IU), 32'(e.done));
            chk("busy", 32'(bus.Busy_IU), 32'(e.busy));
            chk("issue_cnt", 32'(bus.IssueCnt_IU), 32'(e.cnt));
         end
      end
   end

   initial begin
      logic [7:0] g;
      logic [7:0] req, ereq;
      bus.Start_IU = 1'b0;
      bus.WarpMask_IU = '0;
      bus.Req_IB_IU = '0;
      bus.Exit_Req_IB_IU = '0;
      bus.Stall_OC_IU = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_grt", 32'(bus.Grt_IU_IB), 0);
      chk("reset_valid", 32'(bus.Valid_IU_OC), 0);
      chk("reset_busy", 32'(bus.Busy_IU), 0);
      chk("reset_cnt", 32'(bus.IssueCnt_IU), 0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // full round robin from ptr 0
      step(1'b1, 8'hFF, 8'h00, 8'h00, 1'b0, g);
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 8'h00, 8'hFF, 8'h00, 1'b0, g);
         chk("rr_seq", 32'(g), 32'(1 << (i % 8)));
      end
      chk("cnt_after_10", 32'(bus.IssueCnt_IU), 10);

      // move ptr to 5, then wrap-around
      step(1'b0, 8'h00, 8'h10, 8'h00, 1'b0, g);
      step(1'b0, 8'h00, 8'h09, 8'h00, 1'b0, g);
      chk("wrap_first", 32'(g), 32'h01);
      step(1'b0, 8'h00, 8'h09, 8'h00, 1'b0, g);
      chk("wrap_second", 32'(g), 32'h08);
      idle(2);

      // stall holds ptr
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 8'h00, 8'hFF, 8'h00, 1'b1, g);
         chk("stall_grt", 32'(g), 0);
      end
      step(1'b0, 8'h00, 8'hFF, 8'h00, 1'b0, g);
      chk("post_stall", 32'(g), 32'h10);

      // simultaneous issue and exit
      step(1'b0, 8'h00, 8'h02, 8'h10, 1'b0, g);
      chk("dual_issue", 32'(g), 32'h02);
      idle(1);

      // launch ignored while busy
      step(1'b1, 8'hF0, 8'h00, 8'h00, 1'b0, g);
      drain();

      // last two warps exit, done pulse
      step(1'b1, 8'h0C, 8'h00, 8'h00, 1'b0, g);
      step(1'b0, 8'h00, 8'h01, 8'h0C, 1'b0, g);
      chk("inactive_issue", 32'(g), 0);
      step(1'b0, 8'h00, 8'h00, 8'h0C, 1'b0, g);
      chk("done_pulse", 32'(bus.Done_IU), 1);
      idle(2);

      // randomized kernels
      for (int r = 0; r < 4; r++) begin
         step(1'b1, 8'($urandom), 8'h00, 8'h00, 1'b0, g);
         for (int c = 0; c < 60; c++) begin
            req  = 8'($urandom);
            ereq = ($urandom % 6 == 0) ? 8'($urandom) : 8'h00;
            step(($urandom % 16 == 0), 8'($urandom), req, ereq, ($urandom % 4 == 0), g);
         end
         if (r == 2) begin
            bus.Req_IB_IU = 8'hFF;
            mid_reset();
         end else begin
            drain();
         end
      end

      // empty launch after reset
      step(1'b1, 8'h00, 8'hFF, 8'hFF, 1'b0, g);
      step(1'b0, 8'h00, 8'hFF, 8'hFF, 1'b0, g);
      chk("empty_launch_busy", 32'(bus.Busy_IU), 0);
      chk("empty_launch_done", 32'(bus.Done_IU), 0);
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
